// File: rtl/spi_pkg.sv
// Shared constants and mode decode helpers for the SPI peripheral.
package spi_pkg;

  localparam int unsigned SPI_MODE_0 = 0;
  localparam int unsigned SPI_MODE_1 = 1;
  localparam int unsigned SPI_MODE_2 = 2;
  localparam int unsigned SPI_MODE_3 = 3;

  // Byte shifted out when the master clocks a byte that the user never loaded.
  localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_t;

  // Idle level of SCLK.
  function automatic logic spi_cpol(input int unsigned mode);
    return mode[1];
  endfunction

  // 0: sample on the leading edge, 1: sample on the trailing edge.
  function automatic logic spi_cpha(input int unsigned mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Bundle of SPI pins plus the user-side TX/RX handshake of the SPI peripheral.
interface spi_slave_if;
  import spi_pkg::*;

  logic       i_SPI_Clk;
  logic       i_SPI_CS_n;
  logic       i_SPI_MOSI;
  logic       o_SPI_MISO;
  logic       o_SPI_MISO_En;
  logic [7:0] i_TX_Byte;
  logic       i_TX_DV;
  logic       o_TX_Ready;
  logic       o_TX_Underrun;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_CS_Active;

  // Peripheral side.
  modport slave (
    input  i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_TX_Byte, i_TX_DV,
    output o_SPI_MISO, o_SPI_MISO_En, o_TX_Ready, o_TX_Underrun,
           o_RX_DV, o_RX_Byte, o_CS_Active
  );

  // Board / user side driving the peripheral.
  modport master (
    output i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_TX_Byte, i_TX_DV,
    input  o_SPI_MISO, o_SPI_MISO_En, o_TX_Ready, o_TX_Underrun,
           o_RX_DV, o_RX_Byte, o_CS_Active
  );

endinterface

// File: rtl/spi_sync_ff.sv
// Multi-stage 1-bit synchroniser for an asynchronous SPI pin (STAGES >= 2).
module spi_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Plain shift chain; no reset so a reset never fabricates a pin transition.
  always_ff @(posedge clk) begin
    chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI peripheral endpoint: oversamples SCLK/CS_n/MOSI in i_Clk, receives
// bytes MSb-first and serialises a user-loaded byte onto MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MODE    = SPI_MODE_3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  spi_slave_if.slave bus
);

  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);

  logic       sclk_s, cs_n_s, mosi_s;
  logic       sclk_d, cs_n_d;
  logic       sample_p, shift_p, cs_fall_p, cs_rise_p;
  logic       lead_edge, trail_edge;
  spi_state_t state;
  logic       miso, miso_en, cs_active, tx_underrun, rx_dv;
  logic [7:0] rx_byte;
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt, tx_cnt;
  logic [7:0] tx_shift, hold, next_tx;
  logic       hold_full, load_pending, byte_start;

  spi_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(i_Clk), .d(bus.i_SPI_Clk),  .q(sclk_s));
  spi_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs   (.clk(i_Clk), .d(bus.i_SPI_CS_n), .q(cs_n_s));
  spi_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(i_Clk), .d(bus.i_SPI_MOSI), .q(mosi_s));

  assign lead_edge  = (sclk_s != sclk_d) && (sclk_s != CPOL);
  assign trail_edge = (sclk_s != sclk_d) && (sclk_s == CPOL);

  // Edge detection; cs_n_d resets to "asserted" so a CS held low through
  // reset never looks like a fresh falling edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sclk_d    <= CPOL;
      cs_n_d    <= 1'b0;
      sample_p  <= 1'b0;
      shift_p   <= 1'b0;
      cs_fall_p <= 1'b0;
      cs_rise_p <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      cs_n_d    <= cs_n_s;
      sample_p  <= (CPHA ? trail_edge : lead_edge) && !cs_n_s;
      shift_p   <= (CPHA ? lead_edge : trail_edge) && !cs_n_s;
      cs_fall_p <= cs_n_d && !cs_n_s;
      cs_rise_p <= !cs_n_d && cs_n_s;
    end
  end

  // Byte start: CS fall in IDLE, or the shift edge following the 8th sample.
  always_comb begin
    byte_start = 1'b0;
    if (state == ST_IDLE) byte_start = cs_fall_p;
    else                  byte_start = !cs_rise_p && shift_p && load_pending;
    next_tx = hold_full ? hold : SPI_FILL_BYTE;
  end

  // Frame FSM with TX holding register, RX deserialiser and MISO driver.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= ST_IDLE;
      miso         <= 1'b0;
      miso_en      <= 1'b0;
      cs_active    <= 1'b0;
      tx_underrun  <= 1'b0;
      rx_dv        <= 1'b0;
      rx_byte      <= '0;
      rx_shift     <= '0;
      bit_cnt      <= 3'd7;
      tx_cnt       <= 3'd7;
      tx_shift     <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      rx_dv       <= 1'b0;

      if (bus.i_TX_DV && !hold_full) begin
        hold      <= bus.i_TX_Byte;
        hold_full <= 1'b1;
      end

      if (byte_start) begin
        tx_shift     <= next_tx;
        load_pending <= 1'b0;
        if (hold_full) hold_full   <= 1'b0;
        else           tx_underrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall_p) begin
            state     <= ST_ACTIVE;
            cs_active <= 1'b1;
            miso_en   <= 1'b1;
            bit_cnt   <= 3'd7;
            if (!CPHA) begin
              miso   <= next_tx[7];
              tx_cnt <= 3'd6;
            end else begin
              tx_cnt <= 3'd7;
            end
          end
        end
        ST_ACTIVE: begin
          if (cs_rise_p) begin
            state        <= ST_IDLE;
            cs_active    <= 1'b0;
            miso_en      <= 1'b0;
            bit_cnt      <= 3'd7;
            tx_cnt       <= 3'd7;
            load_pending <= 1'b0;
          end else begin
            if (sample_p) begin
              rx_shift <= {rx_shift[5:0], mosi_s};
              bit_cnt  <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                rx_byte      <= {rx_shift, mosi_s};
                rx_dv        <= 1'b1;
                load_pending <= 1'b1;
              end
            end
            if (shift_p) begin
              if (load_pending) begin
                miso   <= next_tx[7];
                tx_cnt <= 3'd6;
              end else begin
                miso   <= tx_shift[tx_cnt];
                tx_cnt <= tx_cnt - 3'd1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_SPI_MISO    = miso;
  assign bus.o_SPI_MISO_En = miso_en;
  assign bus.o_TX_Ready    = !hold_full;
  assign bus.o_TX_Underrun = tx_underrun;
  assign bus.o_RX_DV       = rx_dv;
  assign bus.o_RX_Byte     = rx_byte;
  assign bus.o_CS_Active   = cs_active;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench: one spi_slave per SPI mode sharing SCLK/MOSI, each with its
// own chip select; a behavioural master clocks SCLK at 12x i_Clk period.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [3:0] cs_n = '1;
  logic [3:0] tx_dv = '0;
  logic [7:0] tx_byte [4];

  wire  [3:0] miso, miso_en, tx_ready, underrun, rx_dv, cs_active;
  wire  [7:0] rx_byte [4];

  int          n_checks = 0;
  int          n_fail   = 0;
  time         last_shift_t = 0;
  int unsigned rx_cnt [4];
  int unsigned und_cnt [4];
  int unsigned bad_miso = 0;
  logic [7:0]  rx_hist [4][8];
  logic [3:0]  miso_prev = '0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_if bus ();
    assign bus.i_SPI_Clk  = sclk;
    assign bus.i_SPI_CS_n = cs_n[g];
    assign bus.i_SPI_MOSI = mosi;
    assign bus.i_TX_Byte  = tx_byte[g];
    assign bus.i_TX_DV    = tx_dv[g];
    assign miso[g]        = bus.o_SPI_MISO;
    assign miso_en[g]     = bus.o_SPI_MISO_En;
    assign tx_ready[g]    = bus.o_TX_Ready;
    assign underrun[g]    = bus.o_TX_Underrun;
    assign rx_dv[g]       = bus.o_RX_DV;
    assign rx_byte[g]     = bus.o_RX_Byte;
    assign cs_active[g]   = bus.o_CS_Active;

    spi_slave #(.SPI_MODE(g), .SYNC_STAGES(2)) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus)
    );
  end

  // Pulse counters, RX history, and MISO-timing watch for modes 1 and 2
  // (a MISO change must land exactly 4 cycles after a shift edge / CS fall).
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_dv[i]) begin
        if (rx_cnt[i] < 8) rx_hist[i][rx_cnt[i]] <= rx_byte[i];
        rx_cnt[i] <= rx_cnt[i] + 1;
      end
      if (underrun[i]) und_cnt[i] <= und_cnt[i] + 1;
      if ((i == 1 || i == 2) && !cs_n[i] && (miso[i] != miso_prev[i]) &&
          (($time - last_shift_t) != 40))
        bad_miso <= bad_miso + 1;
    end
    miso_prev <= miso;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic tb_cpol(input int idx);
    return idx[1];
  endfunction

  function automatic logic tb_cpha(input int idx);
    return idx[0];
  endfunction

  task automatic load_tx(input int idx, input logic [7:0] b);
    int t = 0;
    while (!tx_ready[idx] && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("tx_ready_wait", 32'(tx_ready[idx]), 32'd1);
    tx_byte[idx] = b;
    tx_dv[idx]   = 1'b1;
    @(negedge clk);
    tx_dv[idx]   = 1'b0;
  endtask

  task automatic frame_start(input int idx);
    sclk = tb_cpol(idx);
    wait_cycles(10);
    cs_n[idx]    = 1'b0;
    last_shift_t = $time;
    wait_cycles(6);
  endtask

  task automatic frame_end(input int idx);
    cs_n[idx] = 1'b1;
    wait_cycles(10);
  endtask

  // Master side of nbits bit-times, MSb first; returns what it saw on MISO.
  task automatic xfer(input int idx, input logic [7:0] mo, input int nbits,
                      output logic [7:0] mi);
    logic cpol, cpha;
    cpol = tb_cpol(idx);
    cpha = tb_cpha(idx);
    mi   = '0;
    for (int k = 0; k < nbits; k++) begin
      int b;
      b = 7 - k;
      if (!cpha) begin
        mosi = mo[b];
        wait_cycles(6);
        sclk  = ~cpol;
        mi[b] = miso[idx];
        wait_cycles(6);
        sclk         = cpol;
        last_shift_t = $time;
      end else begin
        wait_cycles(6);
        sclk         = ~cpol;
        last_shift_t = $time;
        mosi         = mo[b];
        wait_cycles(6);
        sclk  = cpol;
        mi[b] = miso[idx];
      end
    end
    wait_cycles(6);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete within the time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0]  got;
    int unsigned base;
    for (int i = 0; i < 4; i++) tx_byte[i] = '0;

    // Reset state
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(3);
    check_eq("rst_miso",     32'(miso[3]),      32'd0);
    check_eq("rst_miso_en",  32'(miso_en[3]),   32'd0);
    check_eq("rst_tx_ready", 32'(tx_ready[3]),  32'd1);
    check_eq("rst_underrun", 32'(underrun[3]),  32'd0);
    check_eq("rst_rx_dv",    32'(rx_dv[3]),     32'd0);
    check_eq("rst_rx_byte",  32'(rx_byte[3]),   32'h00);
    check_eq("rst_cs_act",   32'(cs_active[3]), 32'd0);

    // Mode 3: preload A5, master sends 3C
    load_tx(3, 8'hA5);
    frame_start(3);
    check_eq("m3_cs_active", 32'(cs_active[3]), 32'd1);
    check_eq("m3_miso_en",   32'(miso_en[3]),   32'd1);
    check_eq("m3_ready_up",  32'(tx_ready[3]),  32'd1);
    xfer(3, 8'h3C, 8, got);
    frame_end(3);
    check_eq("m3_rx_byte",  32'(rx_byte[3]), 32'h3C);
    check_eq("m3_rx_cnt",   rx_cnt[3],       32'd1);
    check_eq("m3_miso_rx",  32'(got),        32'hA5);
    check_eq("m3_no_under", und_cnt[3],      32'd0);
    check_eq("m3_en_drop",  32'(miso_en[3]), 32'd0);

    // Mode 0: three-byte frame with reloads
    begin
      logic [7:0] g0, g1, g2;
      load_tx(0, 8'hC1);
      frame_start(0);
      load_tx(0, 8'hC2);
      xfer(0, 8'h01, 8, g0);
      load_tx(0, 8'hC3);
      xfer(0, 8'h02, 8, g1);
      xfer(0, 8'h03, 8, g2);
      frame_end(0);
      check_eq("m0_rx_cnt", rx_cnt[0],           32'd3);
      check_eq("m0_rx0",    32'(rx_hist[0][0]),  32'h01);
      check_eq("m0_rx1",    32'(rx_hist[0][1]),  32'h02);
      check_eq("m0_rx2",    32'(rx_hist[0][2]),  32'h03);
      check_eq("m0_miso0",  32'(g0),             32'hC1);
      check_eq("m0_miso1",  32'(g1),             32'hC2);
      check_eq("m0_miso2",  32'(g2),             32'hC3);
    end

    // Modes 1 and 2: 81 each way
    for (int m = 1; m <= 2; m++) begin
      load_tx(m, 8'h81);
      frame_start(m);
      xfer(m, 8'h81, 8, got);
      frame_end(m);
      check_eq($sformatf("m%0d_rx_byte", m), 32'(rx_byte[m]), 32'h81);
      check_eq($sformatf("m%0d_rx_cnt", m),  rx_cnt[m],       32'd1);
      check_eq($sformatf("m%0d_miso_rx", m), 32'(got),        32'h81);
    end
    check_eq("m12_miso_timing", bad_miso, 32'd0);

    // Underrun: no preload in mode 3
    base = und_cnt[3];
    frame_start(3);
    xfer(3, 8'h11, 8, got);
    frame_end(3);
    check_eq("ur_pulses",  und_cnt[3] - base, 32'd1);
    check_eq("ur_fill",    32'(got),          32'hFF);
    check_eq("ur_rx_byte", 32'(rx_byte[3]),   32'h11);

    // CS deasserted after 5 bits, then a full 5A frame
    base = rx_cnt[3];
    frame_start(3);
    xfer(3, 8'hF0, 5, got);
    frame_end(3);
    check_eq("abort_no_dv", rx_cnt[3] - base, 32'd0);
    check_eq("abort_en",    32'(miso_en[3]),  32'd0);
    frame_start(3);
    xfer(3, 8'h5A, 8, got);
    frame_end(3);
    check_eq("after_abort_cnt",  rx_cnt[3] - base, 32'd1);
    check_eq("after_abort_byte", 32'(rx_byte[3]),  32'h5A);

    // Reset mid-byte, bus ignored until next CS fall, then a clean frame
    load_tx(3, 8'h77);
    base = rx_cnt[3];
    frame_start(3);
    xfer(3, 8'hC0, 4, got);
    rst = 1'b1;
    wait_cycles(2);
    check_eq("mid_rst_miso",     32'(miso[3]),      32'd0);
    check_eq("mid_rst_miso_en",  32'(miso_en[3]),   32'd0);
    check_eq("mid_rst_ready",    32'(tx_ready[3]),  32'd1);
    check_eq("mid_rst_underrun", 32'(underrun[3]),  32'd0);
    check_eq("mid_rst_rx_dv",    32'(rx_dv[3]),     32'd0);
    check_eq("mid_rst_rx_byte",  32'(rx_byte[3]),   32'h00);
    check_eq("mid_rst_cs_act",   32'(cs_active[3]), 32'd0);
    rst = 1'b0;
    wait_cycles(4);
    xfer(3, 8'hEE, 8, got);
    check_eq("post_rst_ignored", rx_cnt[3] - base, 32'd0);
    check_eq("post_rst_cs_act",  32'(cs_active[3]), 32'd0);
    frame_end(3);
    load_tx(3, 8'h96);
    frame_start(3);
    xfer(3, 8'h6B, 8, got);
    frame_end(3);
    check_eq("post_rst_rx_byte", 32'(rx_byte[3]),  32'h6B);
    check_eq("post_rst_rx_cnt",  rx_cnt[3] - base, 32'd1);
    check_eq("post_rst_miso",    32'(got),         32'h96);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
